// File: rtl/cpu_pkg.sv
// Shared constants for the memory-to-memory CPU: memory address/write-data
// selector codes used by both the control FSM and mem_unit, plus mem_unit states.
package cpu_pkg;

  localparam logic [1:0] MEMADDR_A    = 2'b00;
  localparam logic [1:0] MEMADDR_B    = 2'b01;
  localparam logic [1:0] MEMADDR_DEST = 2'b10;
  localparam logic [1:0] MEMADDR_SP   = 2'b11;

  localparam logic [1:0] WDATA_B      = 2'b00;
  localparam logic [1:0] WDATA_ALU    = 2'b01;
  localparam logic [1:0] WDATA_A      = 2'b10;
  localparam logic [1:0] WDATA_ZERO   = 2'b11;

  typedef enum logic [1:0] {
    MEM_CLEAR = 2'b00,
    MEM_LOAD  = 2'b01,
    MEM_RUN   = 2'b10
  } mem_state_e;

endpackage

// File: rtl/mem_array.sv
// Register-array memory: one synchronous write port, one asynchronous read port.
// A read of the address being written returns the old word until the edge.
module mem_array #(
  parameter int DATA_W = 16,
  parameter int ADDR_W = 8
) (
  input  logic              clk_i,
  input  logic              we_i,
  input  logic [ADDR_W-1:0] waddr_i,
  input  logic [DATA_W-1:0] wdata_i,
  input  logic [ADDR_W-1:0] raddr_i,
  output logic [DATA_W-1:0] rdata_o
);

  logic [DATA_W-1:0] mem_q [2**ADDR_W];

  always_ff @(posedge clk_i) begin
    if (we_i) begin
      mem_q[waddr_i] <= wdata_i;
    end
  end

  assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/mem_unit.sv
// Unified instruction/data memory: after reset it zero-fills the array, optionally
// streams in a program image, and only then raises memReady to release the CPU.
module mem_unit
  import cpu_pkg::*;
#(
  parameter int DATA_W = 16,
  parameter int ADDR_W = 8
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              regOrPC,
  input  logic [1:0]        memAddr,
  input  logic              writeMem,
  input  logic [1:0]        memWriteData,
  input  logic [DATA_W-1:0] pc,
  input  logic [DATA_W-1:0] regA,
  input  logic [DATA_W-1:0] regB,
  input  logic [DATA_W-1:0] regDest,
  input  logic [DATA_W-1:0] regSP,
  input  logic [DATA_W-1:0] aluOut,
  output logic [DATA_W-1:0] memData,
  input  logic              loadEn,
  input  logic              loadValid,
  input  logic [DATA_W-1:0] loadData,
  input  logic              loadLast,
  output logic              loadReady,
  output logic              memReady
);

  localparam logic [ADDR_W-1:0] PTR_MAX = '1;

  mem_state_e        state_q, state_d;
  logic [ADDR_W-1:0] ptr_q, ptr_d;

  logic [DATA_W-1:0] selAddr;
  logic [DATA_W-1:0] runWdata;
  logic [ADDR_W-1:0] rdAddr;
  logic [ADDR_W-1:0] wrAddr;
  logic [DATA_W-1:0] arrWdata;
  logic              arrWe;
  logic              unusedAddrBits;

  always_comb begin
    selAddr = pc;
    if (regOrPC) begin
      unique case (memAddr)
        MEMADDR_A:    selAddr = regA;
        MEMADDR_B:    selAddr = regB;
        MEMADDR_DEST: selAddr = regDest;
        default:      selAddr = regSP;
      endcase
    end
  end

  // Only the low ADDR_W bits decode; higher addresses alias modulo the depth.
  assign rdAddr         = selAddr[ADDR_W-1:0];
  assign unusedAddrBits = ^selAddr[DATA_W-1:ADDR_W];

  always_comb begin
    runWdata = '0;
    unique case (memWriteData)
      WDATA_B:   runWdata = regB;
      WDATA_ALU: runWdata = aluOut;
      WDATA_A:   runWdata = regA;
      default:   runWdata = '0;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q <= MEM_CLEAR;
      ptr_q   <= '0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
    end
  end

  // The write port is owned by the boot sweep/loader until RUN, so writeMem
  // and the load handshake can never collide.
  always_comb begin
    state_d   = state_q;
    ptr_d     = ptr_q;
    arrWe     = 1'b0;
    wrAddr    = ptr_q;
    arrWdata  = '0;
    loadReady = 1'b0;
    memReady  = 1'b0;
    unique case (state_q)
      MEM_CLEAR: begin
        arrWe = 1'b1;
        ptr_d = ptr_q + 1'b1;
        if (ptr_q == PTR_MAX) begin
          ptr_d   = '0;
          state_d = loadEn ? MEM_LOAD : MEM_RUN;
        end
      end
      MEM_LOAD: begin
        loadReady = 1'b1;
        if (loadValid) begin
          arrWe    = 1'b1;
          arrWdata = loadData;
          ptr_d    = ptr_q + 1'b1;
          if (loadLast) begin
            ptr_d   = '0;
            state_d = MEM_RUN;
          end
        end
      end
      MEM_RUN: begin
        memReady = 1'b1;
        arrWe    = writeMem;
        wrAddr   = rdAddr;
        arrWdata = runWdata;
      end
      default: begin
        state_d = MEM_CLEAR;
        ptr_d   = '0;
      end
    endcase
  end

  mem_array #(
    .DATA_W(DATA_W),
    .ADDR_W(ADDR_W)
  ) u_mem_array (
    .clk_i  (CLK),
    .we_i   (arrWe),
    .waddr_i(wrAddr),
    .wdata_i(arrWdata),
    .raddr_i(rdAddr),
    .rdata_o(memData)
  );

endmodule

// File: tb/tb_mem_unit.sv
// Self-checking bench for mem_unit (ADDR_W=4): directed boot/load/run scenarios
// plus randomized load and run traffic against a plain array reference model.
module tb_mem_unit;
  import cpu_pkg::*;

  localparam int DATA_W = 16;
  localparam int ADDR_W = 4;
  localparam int DEPTH  = 16;

  logic              CLK = 1'b0;
  logic              RST;
  logic              regOrPC;
  logic [1:0]        memAddr;
  logic              writeMem;
  logic [1:0]        memWriteData;
  logic [DATA_W-1:0] pc, regA, regB, regDest, regSP, aluOut;
  logic [DATA_W-1:0] memData;
  logic              loadEn, loadValid, loadLast;
  logic [DATA_W-1:0] loadData;
  logic              loadReady, memReady;

  int          checks = 0;
  int          passes = 0;
  logic [15:0] model [DEPTH];

  mem_unit #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) dut (
    .CLK(CLK), .RST(RST), .regOrPC(regOrPC), .memAddr(memAddr),
    .writeMem(writeMem), .memWriteData(memWriteData), .pc(pc), .regA(regA),
    .regB(regB), .regDest(regDest), .regSP(regSP), .aluOut(aluOut),
    .memData(memData), .loadEn(loadEn), .loadValid(loadValid),
    .loadData(loadData), .loadLast(loadLast), .loadReady(loadReady),
    .memReady(memReady)
  );

  always #5 CLK = ~CLK;

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    if (observed === expected) passes++;
    else $display("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  // Address the spec says is selected, reduced modulo the depth.
  function automatic int modelAddr();
    logic [15:0] a;
    if (!regOrPC) a = pc;
    else if (memAddr == 2'd0) a = regA;
    else if (memAddr == 2'd1) a = regB;
    else if (memAddr == 2'd2) a = regDest;
    else a = regSP;
    return int'(a) % DEPTH;
  endfunction

  function automatic logic [15:0] modelWdata();
    if (memWriteData == 2'd0) return regB;
    if (memWriteData == 2'd1) return aluOut;
    if (memWriteData == 2'd2) return regA;
    return 16'h0000;
  endfunction

  task automatic modelClear();
    for (int i = 0; i < DEPTH; i++) model[i] = 16'h0000;
  endtask

  // Boot sweep: memReady must stay low for exactly DEPTH cycles after reset.
  task automatic runClear();
    for (int i = 0; i < DEPTH; i++) begin
      #1;
      checkOutput("clearNotReady", 32'(memReady), 0);
      checkOutput("clearNoLoadReady", 32'(loadReady), 0);
      tick();
    end
  endtask

  task automatic loadBeat(input logic v, input logic [15:0] d, input logic last);
    loadValid = v;
    loadData  = d;
    loadLast  = last;
    #1;
    checkOutput("loadReadyHigh", 32'(loadReady), 1);
    checkOutput("loadNotRunning", 32'(memReady), 0);
    tick();
  endtask

  task automatic checkAllByPc(input string tag);
    regOrPC = 1'b0;
    writeMem = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      pc = 16'(i);
      #1;
      checkOutput(tag, 32'(memData), 32'(model[i]));
    end
  endtask

  task automatic randomLoad(input int beats);
    int sent = 0;
    int ptr = 0;
    int budget = 0;
    logic stall;
    while (sent < beats && budget < 400) begin
      budget++;
      stall = ($urandom_range(0, 2) == 0);
      loadValid = !stall;
      loadData  = 16'($urandom);
      loadLast  = stall ? 1'($urandom) : (sent == beats - 1);
      #1;
      checkOutput("rndLoadReady", 32'(loadReady), 1);
      tick();
      if (!stall) begin
        model[ptr] = loadData;
        ptr = (ptr + 1) % DEPTH;
        sent++;
      end
    end
    loadValid = 1'b0;
    loadLast  = 1'b0;
    checkOutput("rndLoadBeatsSent", 32'(sent), 32'(beats));
  endtask

  task automatic applyStimulus();
    int a;
    logic [15:0] wd;
    logic we;
    regOrPC      = 1'($urandom);
    memAddr      = 2'($urandom);
    memWriteData = 2'($urandom);
    writeMem     = 1'($urandom);
    pc      = 16'($urandom);
    regA    = 16'($urandom);
    regB    = 16'($urandom);
    regDest = 16'($urandom);
    regSP   = 16'($urandom);
    aluOut  = 16'($urandom);
    #1;
    a  = modelAddr();
    wd = modelWdata();
    we = writeMem;
    checkOutput("runRead", 32'(memData), 32'(model[a]));
    checkOutput("runReady", 32'(memReady), 1);
    tick();
    if (we) model[a] = wd;
  endtask

  initial begin
    RST = 1'b1; regOrPC = 1'b0; memAddr = 2'b00; writeMem = 1'b0; memWriteData = 2'b00;
    pc = '0; regA = '0; regB = '0; regDest = '0; regSP = '0; aluOut = '0;
    loadEn = 1'b0; loadValid = 1'b0; loadData = '0; loadLast = 1'b0;

    // Plain boot with writeMem asserted toward mem[2] the whole time.
    regOrPC = 1'b1; memAddr = MEMADDR_A; regA = 16'd2; memWriteData = WDATA_A; writeMem = 1'b1;
    tick();
    RST = 1'b0;
    runClear();
    writeMem = 1'b0;
    #1;
    checkOutput("readyAfterClear", 32'(memReady), 1);
    checkOutput("loadReadyInRun", 32'(loadReady), 0);
    checkOutput("mem2StaysZero", 32'(memData), 0);
    modelClear();
    checkAllByPc("sweepZero");

    // Boot with program load, one stall cycle, writeMem held toward mem[5].
    RST = 1'b1; regOrPC = 1'b1; memAddr = MEMADDR_B; regB = 16'd5;
    memWriteData = WDATA_B; writeMem = 1'b1;
    tick();
    RST = 1'b0; loadEn = 1'b1;
    runClear();
    loadBeat(1'b1, 16'h1111, 1'b0);
    loadBeat(1'b0, 16'h7777, 1'b1);
    loadBeat(1'b1, 16'h2222, 1'b0);
    loadBeat(1'b1, 16'h3333, 1'b1);
    writeMem = 1'b0; loadEn = 1'b0;
    #1;
    checkOutput("readyAfterLoad", 32'(memReady), 1);
    checkOutput("loadReadyDrops", 32'(loadReady), 0);
    modelClear();
    model[0] = 16'h1111; model[1] = 16'h2222; model[2] = 16'h3333;
    checkAllByPc("afterLoad");

    // Write through regDest/aluOut: old value this cycle, new value next.
    regOrPC = 1'b1; memAddr = MEMADDR_DEST; regDest = 16'd5; aluOut = 16'hBEEF;
    memWriteData = WDATA_ALU; writeMem = 1'b1;
    #1;
    checkOutput("sameCycleOld", 32'(memData), 32'(model[5]));
    tick();
    writeMem = 1'b0;
    #1;
    checkOutput("nextCycleNew", 32'(memData), 32'hBEEF);
    model[5] = 16'hBEEF;

    // Stack push, zero write and address aliasing through regSP.
    memAddr = MEMADDR_SP; regSP = 16'h000E; regB = 16'h00AA; memWriteData = WDATA_B; writeMem = 1'b1;
    tick();
    writeMem = 1'b0;
    #1;
    checkOutput("pushWrite", 32'(memData), 32'h00AA);
    memWriteData = WDATA_ZERO; writeMem = 1'b1;
    tick();
    writeMem = 1'b0;
    #1;
    checkOutput("zeroWrite", 32'(memData), 0);
    regSP = 16'h001E; regB = 16'h0055; memWriteData = WDATA_B; writeMem = 1'b1;
    tick();
    writeMem = 1'b0; regSP = 16'h000E;
    #1;
    checkOutput("aliasWrite", 32'(memData), 32'h0055);
    model[14] = 16'h0055;
    checkAllByPc("afterDirected");

    for (int i = 0; i < 150; i++) applyStimulus();
    writeMem = 1'b0;

    // Reset in the middle of a load restarts the full clear.
    RST = 1'b1; loadEn = 1'b1;
    tick();
    RST = 1'b0;
    runClear();
    loadBeat(1'b1, 16'hABCD, 1'b0);
    loadValid = 1'b0;
    RST = 1'b1;
    tick();
    RST = 1'b0; loadEn = 1'b0;
    #1;
    checkOutput("midLoadRstReady", 32'(memReady), 0);
    checkOutput("midLoadRstLoadReady", 32'(loadReady), 0);
    runClear();
    #1;
    checkOutput("readyAfterReclear", 32'(memReady), 1);
    modelClear();
    checkAllByPc("afterReclear");

    // Randomized load that wraps past the depth, with random stalls.
    RST = 1'b1; loadEn = 1'b1;
    tick();
    RST = 1'b0;
    runClear();
    modelClear();
    randomLoad(20);
    loadEn = 1'b0;
    #1;
    checkOutput("readyAfterRndLoad", 32'(memReady), 1);
    checkAllByPc("afterRndLoad");
    for (int i = 0; i < 150; i++) applyStimulus();
    checkAllByPc("final");

    $display("[TB] %0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
